motor_ctl_multi: RTL and testbench

MOTOR_CTL_MULTI -- requirements
Module: motor_ctl_multi

---
 rtl/motor_ctl_multi_if.sv | 14 +
 rtl/motor_ctl_multi.sv | 200 ++++++++++++++++++++
 tb/tb_motor_ctl_multi.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/motor_ctl_multi_if.sv
// Command/status bus of motor_ctl_multi: 32-bit command write port and 32-bit status read port.
interface motor_ctl_multi_if;
  logic [31:0] din_32;
  logic        wr_en_32;
  logic        full_32;
  logic [31:0] dout_32;
  logic        rd_en_32;
  logic        empty_32;

  modport master (output din_32, wr_en_32, rd_en_32,
                  input  full_32, dout_32, empty_32);
  modport slave  (input  din_32, wr_en_32, rd_en_32,
                  output full_32, dout_32, empty_32);
endinterface

// File: rtl/motor_ctl_multi.sv
// Multi-channel PWM motor controller: command FIFO -> control FSM -> status FIFO, shared PWM counter.
// Optional watchdog enabled by defining MOTOR_CTL_WDT_EN.
module motor_ctl_multi_fifo #(
  parameter int unsigned DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic        wr,
  output logic        full,
  input  logic        rd,
  output logic [31:0] rdata,
  output logic        empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          wr_ok, rd_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // a write while full is dropped even if a read frees a slot in the same cycle
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr];
      end
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end
endmodule

module motor_ctl_multi #(
  parameter int unsigned CH       = 2,
  parameter int unsigned PWM_W    = 15,
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned DEAD_CYC = 16,
  parameter int unsigned WDT_CYC  = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  motor_ctl_multi_if.slave   bus,
  output logic [CH-1:0]      dir_out,
  output logic [CH-1:0]      en_out
);
  localparam int unsigned DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [PWM_W-1:0] PWM_TOP = {{(PWM_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, FETCH, APPLY, REPORT} state_t;
  state_t state, nxt;

  logic        cmd_rd, cmd_empty, cmd_full_unused;
  logic [31:0] cmd_data;
  logic        stat_wr, stat_full;
  logic [31:0] stat_word;

  motor_ctl_multi_fifo #(.DEPTH(DEPTH)) u_cmd (
    .clk(clk), .rst(rst),
    .wdata(bus.din_32), .wr(bus.wr_en_32), .full(bus.full_32),
    .rd(cmd_rd), .rdata(cmd_data), .empty(cmd_empty)
  );

  motor_ctl_multi_fifo #(.DEPTH(DEPTH)) u_stat (
    .clk(clk), .rst(rst),
    .wdata(stat_word), .wr(stat_wr), .full(stat_full),
    .rd(bus.rd_en_32), .rdata(bus.dout_32), .empty(bus.empty_32)
  );

  assign cmd_full_unused = ^cmd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    cmd_rd  = 1'b0;
    stat_wr = 1'b0;
    case (state)
      IDLE:   if (!cmd_empty) nxt = FETCH;
      FETCH:  begin
        cmd_rd = 1'b1;
        nxt    = APPLY;
      end
      APPLY:  nxt = REPORT;
      REPORT: if (!stat_full) begin
        stat_wr = 1'b1;
        nxt     = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  logic             c_dir, c_bc, c_valid, apply;
  logic [PWM_W-1:0] c_duty;
  logic [3:0]       c_ch;
  logic [CH-1:0]    hit;

  assign apply   = (state == APPLY);
  assign c_dir   = cmd_data[0];
  assign c_duty  = cmd_data[PWM_W:1];
  assign c_ch    = cmd_data[19:16];
  assign c_bc    = cmd_data[31];
  assign c_valid = c_bc || (32'(c_ch) < CH);

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < CH; i++)
      hit[i] = apply && (c_bc || (32'(c_ch) == i));
  end

  logic wdt_fire, trip;
`ifdef MOTOR_CTL_WDT_EN
  logic [31:0] wdt_cnt;

  assign wdt_fire = !apply && (wdt_cnt >= WDT_CYC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt <= '0;
      trip    <= 1'b0;
    end else begin
      if (apply) begin
        wdt_cnt <= '0;
        if (c_valid) trip <= 1'b0;
      end else if (wdt_cnt < WDT_CYC) begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
      if (wdt_fire) trip <= 1'b1;
    end
  end
`else
  assign wdt_fire = 1'b0;
  assign trip     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_word <= '0;
    else if (apply)
      stat_word <= {~c_valid, trip, 10'd0, (c_bc ? 4'd0 : c_ch), 15'(c_duty), c_dir};
  end

  logic [CH-1:0][PWM_W-1:0] duty;
  logic [CH-1:0]            dir;
  logic [CH-1:0][DW-1:0]    dead;
  logic [PWM_W-1:0]         pwm_cnt;

  // dir_out flips together with the dead-time load, so the motor sees the new
  // direction only while its enable is held low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      dir  <= '0;
      dead <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (hit[i]) begin
          duty[i] <= c_duty;
          dir[i]  <= c_dir;
        end else if (wdt_fire) begin
          duty[i] <= '0;
        end
        if (hit[i] && (c_dir != dir[i])) dead[i] <= DW'(DEAD_CYC);
        else if (dead[i] != '0)          dead[i] <= dead[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     pwm_cnt <= '0;
    else if (pwm_cnt == PWM_TOP) pwm_cnt <= '0;
    else                         pwm_cnt <= pwm_cnt + 1'b1;
  end

  always_comb begin
    en_out = '0;
    for (int unsigned i = 0; i < CH; i++)
      en_out[i] = (pwm_cnt < duty[i]) && (dead[i] == '0);
  end

  assign dir_out = dir;
endmodule

// File: tb/tb_motor_ctl_multi.sv
// Directed bench for motor_ctl_multi with a status-word scoreboard.
module tb_motor_ctl_multi;
  localparam int unsigned CH    = 2;
  localparam int unsigned PWM_W = 15;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DEAD  = 16;
  localparam int unsigned WDT   = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] dir_out, en_out;

  motor_ctl_multi_if bus();

  motor_ctl_multi #(
    .CH(CH), .PWM_W(PWM_W), .DEPTH(DEPTH), .DEAD_CYC(DEAD), .WDT_CYC(WDT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dir_out(dir_out), .en_out(en_out)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] exp_status(input logic [31:0] c, input logic tr);
    logic [3:0] ch;
    logic       bc, err;
    ch  = c[19:16];
    bc  = c[31];
    err = !bc && (32'(ch) >= CH);
    return {err, tr, 10'd0, (bc ? 4'd0 : ch), c[15:1], c[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] c, input bit expect_push, input logic tr);
    bus.din_32   = c;
    bus.wr_en_32 = 1'b1;
    if (expect_push) sb.push_back(exp_status(c, tr));
    tick(1);
    bus.wr_en_32 = 1'b0;
  endtask

  task automatic read_status(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (bus.empty_32 && n < 50) begin
      tick(1);
      n++;
    end
    if (n == 50) begin
      chk({tag, "_timeout"}, 32'(bus.empty_32), 32'd0);
      return;
    end
    bus.rd_en_32 = 1'b1;
    tick(1);
    bus.rd_en_32 = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_unexpected"}, bus.dout_32, 32'hxxxx_xxxx);
      return;
    end
    e = sb.pop_front();
    chk(tag, bus.dout_32, e);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [31:0] c;

    rst          = 1'b1;
    bus.din_32   = '0;
    bus.wr_en_32 = 1'b0;
    bus.rd_en_32 = 1'b0;
    tick(2);
    chk("rst_empty", 32'(bus.empty_32), 32'd1);
    chk("rst_full",  32'(bus.full_32),  32'd0);
    chk("rst_dout",  bus.dout_32,       32'd0);
    chk("rst_en",    32'(en_out),       32'd0);
    chk("rst_dir",   32'(dir_out),      32'd0);
    rst = 1'b0;
    tick(2);

    // ch1 duty 16 dir 1: update on the 4th edge, status on the 5th
    send(32'h0001_0021, 1'b1, 1'b0);
    tick(2);
    chk("lat_dir_before", 32'(dir_out[1]), 32'd0);
    tick(1);
    chk("lat_dir_after", 32'(dir_out[1]), 32'd1);
    chk("lat_dead_en",   32'(en_out[1]),  32'd0);
    chk("lat_empty_before_push", 32'(bus.empty_32), 32'd1);
    tick(1);
    chk("lat_empty_after_push", 32'(bus.empty_32), 32'd0);
    read_status("st_ch1");
    tick(20);
    cnt = 0;
    for (int k = 0; k < 32767; k++) begin
      if (en_out[1]) cnt++;
      tick(1);
    end
    chk("pwm_ch1_high_count", 32'(cnt), 32'd16);

    // ch0 full duty dir 0, then reverse
    send(32'h0000_FFFE, 1'b1, 1'b0);
    tick(4);
    chk("max_duty_en", 32'(en_out[0]), 32'd1);
    read_status("st_ch0_max");
    send(32'h0000_FFFF, 1'b1, 1'b0);
    tick(3);
    chk("rev_dir", 32'(dir_out[0]), 32'd1);
    cnt = 0;
    while (!en_out[0] && cnt < 40) begin
      cnt++;
      tick(1);
    end
    chk("dead_low_cycles", 32'(cnt), 32'd16);
    chk("dead_then_high", 32'(en_out[0]), 32'd1);
    read_status("st_ch0_rev");

    // invalid channel
    send(32'h0005_0040, 1'b1, 1'b0);
    tick(6);
    chk("badch_dir", 32'(dir_out), 32'd3);
    chk("badch_en0", 32'(en_out[0]), 32'd1);
    read_status("st_badch");

    // broadcast reports channel 0 and reverses both channels
    send(32'h8003_0010, 1'b1, 1'b0);
    tick(3);
    chk("bc_dir", 32'(dir_out), 32'd0);
    chk("bc_en",  32'(en_out),  32'd0);
    read_status("st_bc");

    // status FIFO fill, stall, command FIFO fill
    for (int k = 0; k < int'(DEPTH); k++) send($urandom & 32'hFFF3_FFFF, 1'b1, 1'b0);
    tick(8 * 5 + 10);
    chk("fill_not_empty", 32'(bus.empty_32), 32'd0);
    send($urandom & 32'hFFF3_FFFF, 1'b1, 1'b0);
    tick(10);
    for (int k = 0; k < int'(DEPTH) - 1; k++) send($urandom & 32'hFFF3_FFFF, 1'b1, 1'b0);
    chk("cmd_full_one_short", 32'(bus.full_32), 32'd0);
    send($urandom & 32'hFFF3_FFFF, 1'b1, 1'b0);
    chk("cmd_full", 32'(bus.full_32), 32'd1);
    send(32'h0000_0002, 1'b0, 1'b0);
    for (int k = 0; k < 2 * int'(DEPTH) + 1; k++) read_status($sformatf("drain_%0d", k));
    tick(20);
    chk("drain_empty", 32'(bus.empty_32), 32'd1);
    chk("drain_sb_left", 32'(sb.size()), 32'd0);

    // reset while the command sits in REPORT
    send(32'h0001_0041, 1'b0, 1'b0);
    tick(3);
    rst = 1'b1;
    #1;
    chk("midrst_en",    32'(en_out),       32'd0);
    chk("midrst_dir",   32'(dir_out),      32'd0);
    chk("midrst_empty", 32'(bus.empty_32), 32'd1);
    chk("midrst_dout",  bus.dout_32,       32'd0);
    tick(2);
    rst = 1'b0;
    tick(10);
    chk("midrst_no_push", 32'(bus.empty_32), 32'd1);

`ifdef MOTOR_CTL_WDT_EN
    send(32'h0001_00C8, 1'b1, 1'b0);
    tick(5);
    read_status("wdt_first");
    tick(WDT + 5);
    chk("wdt_en_low", 32'(en_out), 32'd0);
    send(32'h0000_0010, 1'b1, 1'b1);
    read_status("wdt_trip_flag");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
